// File: rtl/alu_scheduler.sv
// alu_scheduler
//   Two-requester round-robin front end for a bit-serial 4-bit ALU.
//   A granted request is executed LSB first through a single 1-bit slice,
//   one bit per clock, with a carry flop between bits. The result is then
//   announced with a one-cycle res_valid pulse.
//
//   state | meaning
//   IDLE  | arbitrate; ready goes to the granted requester; transfer on valid&ready
//   EXEC  | process bit bit_cnt (0..3) of the latched operands
//   DONE  | res_valid pulse, then back to IDLE
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   reqN_valid/op/a/b/cin    request from requester N (N = 0, 1)
//   reqN_ready               combinational accept for requester N (IDLE only)
//   res_valid                one-cycle result strobe
//   res_id, res_y, res_cout  registered result owner, word and carry-out
module alu_scheduler (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [2:0] req0_op,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  input  logic       req0_cin,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [2:0] req1_op,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  input  logic       req1_cin,
  output logic       req1_ready,
  output logic       res_valid,
  output logic       res_id,
  output logic [3:0] res_y,
  output logic       res_cout
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t     state, state_nxt;
  logic       last_grant;
  logic       grant_id;
  logic       transfer;
  logic [2:0] op_q;
  logic [3:0] a_q, b_q;
  logic       id_q;
  logic       carry;
  logic [1:0] bit_cnt;
  logic       ai, bi;
  logic       slice_y, slice_c;

  // Arbitration, handshake and next state.
  always_comb begin
    state_nxt  = state;
    grant_id   = 1'b0;
    transfer   = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    res_valid  = 1'b0;
    // On a tie, the requester not granted last wins; otherwise the lone one.
    if (req0_valid && req1_valid) grant_id = ~last_grant;
    else                          grant_id = req1_valid;
    case (state)
      IDLE: begin
        // Ready is held low while reset is asserted even though state is IDLE.
        transfer   = (req0_valid || req1_valid) && !rst;
        req0_ready = transfer && !grant_id;
        req1_ready = transfer && grant_id;
        if (transfer) state_nxt = EXEC;
      end
      EXEC: if (bit_cnt == 2'd3) state_nxt = DONE;
      DONE: begin
        res_valid = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The single 1-bit ALU slice.
  always_comb begin
    ai      = a_q[bit_cnt];
    bi      = b_q[bit_cnt];
    slice_y = 1'b0;
    slice_c = carry;
    case (op_q)
      3'b000: slice_y = ai | bi;
      3'b001: slice_y = ai & bi;
      3'b010: slice_y = ~ai;
      3'b011: slice_y = ~(ai | bi);
      3'b100: slice_y = ~(ai & bi);
      3'b101: slice_y = ai;
      default: begin
        slice_y = ai ^ bi ^ carry;
        slice_c = (ai & bi) | (carry & (ai ^ bi));
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      op_q       <= 3'b000;
      a_q        <= 4'b0000;
      b_q        <= 4'b0000;
      id_q       <= 1'b0;
      carry      <= 1'b0;
      bit_cnt    <= 2'd0;
      res_id     <= 1'b0;
      res_y      <= 4'b0000;
      res_cout   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (transfer) begin
        last_grant <= grant_id;
        id_q       <= grant_id;
        bit_cnt    <= 2'd0;
        if (grant_id) begin
          op_q  <= req1_op;
          a_q   <= req1_a;
          b_q   <= req1_b;
          carry <= (req1_op == 3'b111) ? req1_cin : 1'b0;
        end else begin
          op_q  <= req0_op;
          a_q   <= req0_a;
          b_q   <= req0_b;
          carry <= (req0_op == 3'b111) ? req0_cin : 1'b0;
        end
      end else if (state == EXEC) begin
        res_y[bit_cnt] <= slice_y;
        carry          <= slice_c;
        bit_cnt        <= bit_cnt + 2'd1;
        if (bit_cnt == 2'd3) begin
          res_id   <= id_q;
          res_cout <= (op_q[2:1] == 2'b11) ? slice_c : 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_scheduler.sv
// tb_alu_scheduler
//   Directed bench for alu_scheduler: reset values, the listed scenarios,
//   round-robin arbitration, abort by reset, and a full sweep of opcodes,
//   operands and carry-in against a small arithmetic reference.
module tb_alu_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req0_cin, req0_ready;
  logic [2:0] req0_op;
  logic [3:0] req0_a, req0_b;
  logic       req1_valid, req1_cin, req1_ready;
  logic [2:0] req1_op;
  logic [3:0] req1_a, req1_b;
  logic       res_valid, res_id, res_cout;
  logic [3:0] res_y;

  int total = 0;
  int bad   = 0;

  alu_scheduler dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req0_cin(req0_cin), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .req1_cin(req1_cin), .req1_ready(req1_ready),
    .res_valid(res_valid), .res_id(res_id), .res_y(res_y), .res_cout(res_cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Independent reference: arithmetic sum for adds, whole-word logic otherwise.
  task automatic ref_model(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                           input logic cin, output logic [3:0] y, output logic co);
    logic [4:0] s;
    co = 1'b0;
    case (op)
      3'd0: y = a | b;
      3'd1: y = a & b;
      3'd2: y = ~a;
      3'd3: y = ~(a | b);
      3'd4: y = ~(a & b);
      3'd5: y = a;
      3'd6: begin s = {1'b0, a} + {1'b0, b};               y = s[3:0]; co = s[4]; end
      default: begin s = {1'b0, a} + {1'b0, b} + {4'd0, cin}; y = s[3:0]; co = s[4]; end
    endcase
  endtask

  // Wait (bounded) for res_valid, sampled on negedges; returns cycles waited.
  task automatic wait_res(output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!res_valid && k < 12);
  endtask

  // Issue one request from requester id, expect result 5 cycles after transfer.
  task automatic do_op(input string tag, input logic id, input logic [2:0] op,
                       input logic [3:0] a, input logic [3:0] b, input logic cin,
                       input logic [3:0] ey, input logic ec, input logic scramble);
    int k;
    if (id) begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; req1_cin = cin;
    end else begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; req0_cin = cin;
    end
    #1;
    chk({tag, "_ready"}, {6'd0, req1_ready, req0_ready}, id ? 8'h2 : 8'h1);
    @(posedge clk);
    #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    if (scramble) begin
      req0_a = ~a; req0_b = ~b; req0_cin = ~cin; req0_op = 3'd7;
      req1_a = ~a; req1_b = ~b; req1_cin = ~cin; req1_op = 3'd7;
    end
    wait_res(k);
    chk({tag, "_lat"}, k[7:0], 8'd5);
    chk({tag, "_res"}, {2'd0, res_id, res_cout, res_y}, {2'd0, id, ec, ey});
    @(negedge clk);
    chk({tag, "_hold"}, {1'b0, res_valid, res_id, res_cout, res_y}, {2'd0, id, ec, ey});
  endtask

  initial begin
    int k;
    logic [3:0] ey;
    logic ec;
    rst = 1'b1;
    req0_valid = 1'b1; req0_op = 3'd0; req0_a = 4'd0; req0_b = 4'd0; req0_cin = 1'b0;
    req1_valid = 1'b1; req1_op = 3'd0; req1_a = 4'd0; req1_b = 4'd0; req1_cin = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_out", {1'b0, req1_ready, req0_ready, res_valid, res_id, res_cout, 2'd0},
        8'h00);
    chk("reset_y", {4'd0, res_y}, 8'h00);
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    do_op("addc", 1'b0, 3'b111, 4'b1011, 4'b0110, 1'b1, 4'b0010, 1'b1, 1'b0);
    do_op("add1", 1'b1, 3'b110, 4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0);
    do_op("not1", 1'b1, 3'b010, 4'b1010, 4'b0000, 1'b0, 4'b0101, 1'b0, 1'b0);
    do_op("noop", 1'b0, 3'b101, 4'b1001, 4'b0110, 1'b1, 4'b1001, 1'b0, 1'b1);

    // Round robin with both valid from reset release: grants 0,1,0.
    rst = 1'b1;
    req0_valid = 1'b1; req0_op = 3'b000; req0_a = 4'b0101; req0_b = 4'b0011;
    req1_valid = 1'b1; req1_op = 3'b100; req1_a = 4'b1100; req1_b = 4'b1010;
    @(negedge clk);
    chk("rr_in_reset", {6'd0, req1_ready, req0_ready}, 8'h0);
    rst = 1'b0;
    #1;
    chk("rr_first_edge", {6'd0, req1_ready, req0_ready}, 8'h1);
    for (int g = 0; g < 3; g++) begin
      k = 0;
      while (!(req0_ready || req1_ready) && k < 12) begin
        @(negedge clk);
        k++;
      end
      chk("rr_grant", {6'd0, req1_ready, req0_ready}, (g == 1) ? 8'h2 : 8'h1);
      @(posedge clk);
      #1;
      wait_res(k);
      chk("rr_lat", k[7:0], 8'd5);
      chk("rr_res", {3'd0, res_id, res_y}, {3'd0, (g == 1), 4'b0111});
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);

    // Reset during the second EXEC cycle of an ADDC aborts it.
    req0_valid = 1'b1; req0_op = 3'b111; req0_a = 4'b0111; req0_b = 4'b0101; req0_cin = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_out", {1'b0, req1_ready, req0_ready, res_valid, res_id, res_cout, 2'd0}, 8'h00);
    chk("abort_y", {4'd0, res_y}, 8'h00);
    req0_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    k = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (res_valid) k++;
    end
    chk("abort_nopulse", k[7:0], 8'd0);
    do_op("abort_retry", 1'b0, 3'b111, 4'b0111, 4'b0101, 1'b1, 4'b1101, 1'b0, 1'b0);

    // Full sweep, alternating requesters.
    for (int op = 0; op < 8; op++)
      for (int ab = 0; ab < 256; ab++)
        for (int ci = 0; ci < 2; ci++) begin
          ref_model(op[2:0], ab[7:4], ab[3:0], ci[0], ey, ec);
          do_op("sweep", ab[0] ^ ci[0], op[2:0], ab[7:4], ab[3:0], ci[0], ey, ec, 1'b1);
        end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_scheduler.md
ALU_SCHEDULER -- requirements
Module: alu_scheduler

Interface
REQ-001 Parameter: none; operand width fixed at 4 bits, opcode width fixed at 3 bits.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_op  input  3  requester 0 opcode.
REQ-006 req0_a, req0_b  input  4 each  requester 0 operands.
REQ-007 req0_cin  input  1  requester 0 carry-in, used by opcode 111 only.
REQ-008 req0_ready  output  1  requester 0 request accepted this cycle.
REQ-009 req1_valid, req1_op, req1_a, req1_b, req1_cin, req1_ready  same widths and meanings for requester 1.
REQ-010 res_valid  output  1  one-cycle pulse; the result is valid.
REQ-011 res_id  output  1  index of the requester that owns the result.
REQ-012 res_y  output  4  result word.
REQ-013 res_cout  output  1  carry-out; 0 for non-arithmetic opcodes.

Function
REQ-014 Opcode map (bitwise, per bit i):
- 000 OR a|b
- 001 AND a&b
- 010 NOT ~a
- 011 NOR ~(a|b)
- 100 NAND ~(a&b)
- 101 NOOP pass a
- 110 ADD a+b with carry-in 0
- 111 ADDC a+b+cin
REQ-015 Execution SHALL be bit-serial through one internal 1-bit slice, LSB first, one bit per cycle, with a carry flip-flop between bits.
REQ-016 FSM states SHALL be IDLE, EXEC and DONE.
REQ-017 IDLE: when no request is valid, the FSM SHALL stay in IDLE; when any request is valid, the FSM SHALL grant exactly one and move to EXEC.
REQ-018 Handshake: reqN_ready SHALL be combinational and asserted only in IDLE, only for the granted requester; the transfer occurs when reqN_valid and reqN_ready are both high.
REQ-019 On transfer, the block SHALL latch op, a, b and the requester id, and SHALL load the carry:
- cin for op 111
- 0 for all other opcodes
REQ-020 Arbitration SHALL be round-robin:
- with both requesters valid, grant the one not granted last;
- with a single requester valid, grant it regardless of history.
REQ-021 The last-grant register SHALL update only on a transfer.
REQ-022 EXEC: a 2-bit bit counter SHALL run 0..3, and each cycle SHALL write slice output bit i into res_y[i] and update the carry.
REQ-023 After bit 3, the FSM SHALL move to DONE.
REQ-024 DONE: res_valid SHALL be high for exactly one cycle, and the FSM SHALL then return to IDLE.
REQ-025 Timing: transfer at cycle T, EXEC at T+1..T+4, res_valid at T+5; the earliest next transfer is at T+6.
REQ-026 res_y, res_cout and res_id SHALL be registered and SHALL hold their values after DONE until the next result overwrites them.
REQ-027 res_cout SHALL equal the final carry for 110/111 and SHALL be forced to 0 for all other opcodes.
REQ-028 Requests asserted during EXEC/DONE SHALL see ready low and SHALL NOT be lost, provided the requester holds valid.
REQ-029 Input changes after transfer SHALL NOT affect the in-flight result.
REQ-030 Undriven or unknown opcodes: not applicable; all 8 codes are defined.

Reset
REQ-031 While rst is high:
- state = IDLE
- bit counter = 0
- carry = 0
- res_valid = 0, res_y = 0, res_cout = 0, res_id = 0
- last-grant = 1, so requester 0 wins the first tie
- both readys = 0
REQ-032 Reset asserted mid-EXEC SHALL abort the operation with no res_valid pulse; the requester SHALL re-request.
REQ-033 After rst deasserts, the first transfer SHALL be possible on the first clock edge.

Verification
REQ-034 req0 op=111 a=1011 b=0110 cin=1 -> res_valid 5 cycles after transfer; res_y=0010, res_cout=1, res_id=0.
REQ-035 req1 alone, op=110 a=1111 b=0001 -> res_y=0000, res_cout=1, res_id=1; then op=010 a=1010 -> res_y=0101, res_cout=0.
REQ-036 Both valid continuously after reset, req0 op=000 a=0101 b=0011, req1 op=100 a=1100 b=1010 -> grants alternate 0,1,0; results 0111 (id 0), 0111 (id 1), 0111 (id 0); exactly one ready high per transfer.
REQ-037 req0 op=101 a=1001 with b and cin changed during EXEC -> res_y=1001, res_cout=0.
REQ-038 rst pulsed at the 2nd EXEC cycle of an ADDC -> no res_valid, outputs zero, next request granted cleanly with correct result.
REQ-039 Exhaustive loop: all 8 opcodes x all 256 a/b pairs x cin, compared against a reference model.
